// File: rtl/updown_sweep_pkg.sv
// -----------------------------------------------------------------------------
// updown_sweep_pkg
// Shared definitions for the up/down sweep controller:
//   - DEFAULT_W  : default count / bound / dwell width
//   - MODE_UP / MODE_DOWN : counter direction encoding
//   - state_t    : controller state enumeration (3-bit, IDLE = 0)
// -----------------------------------------------------------------------------
package updown_sweep_pkg;

   localparam int DEFAULT_W = 4;

   localparam logic MODE_UP   = 1'b0;
   localparam logic MODE_DOWN = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_UP       = 3'd1,
      ST_DWELL_HI = 3'd2,
      ST_DOWN     = 3'd3,
      ST_DWELL_LO = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

endpackage

// File: rtl/up_down_counter_ld.sv
// -----------------------------------------------------------------------------
// up_down_counter_ld
// W-bit up/down counter with synchronous parallel load.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, clears count
//   load  : load din on this edge (has priority over en)
//   din   : parallel load value
//   en    : step the counter on this edge
//   mode  : direction, MODE_UP (0) increments, MODE_DOWN (1) decrements
//   count : current counter value
// -----------------------------------------------------------------------------
module up_down_counter_ld
   import updown_sweep_pkg::*;
#(
   parameter int W = DEFAULT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] din,
   input  logic         en,
   input  logic         mode,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] r_count;

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register samples the values from before the clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= din;
      end else if (en) begin
         r_count <= (mode == MODE_DOWN) ? (r_count - ONE) : (r_count + ONE);
      end
   end

   assign count = r_count;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// updown_sweep_ctrl
// Drives an up/down counter in a bounded ping-pong sweep between lo and hi,
// with an optional dwell at each bound and a programmable sweep count.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   start    : request, sampled only in IDLE (bounds latched on acceptance)
//   stop     : abort, sampled in every state, wins over start
//   lo, hi   : sweep bounds (lo must be below hi, otherwise err pulses)
//   dwell    : extra hold cycles at each bound, 0 = none
//   sweeps   : number of up-then-down sweeps, 0 = run until stop
//   count    : counter value
//   mode     : direction driven to the counter (1 in DOWN and DWELL_HI)
//   cnt_en   : counter steps (UP and DOWN)
//   busy     : controller not in IDLE
//   done     : one-cycle pulse in the DONE cycle
//   err      : one-cycle pulse after a rejected start
// -----------------------------------------------------------------------------
module updown_sweep_ctrl
   import updown_sweep_pkg::*;
#(
   parameter int W = DEFAULT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         stop,
   input  logic [W-1:0] lo,
   input  logic [W-1:0] hi,
   input  logic [W-1:0] dwell,
   input  logic [W-1:0] sweeps,
   output logic [W-1:0] count,
   output logic         mode,
   output logic         cnt_en,
   output logic         busy,
   output logic         done,
   output logic         err
);

   localparam logic [W-1:0] ONE = W'(1);

   state_t       r_state;
   state_t       w_next_state;

   logic [W-1:0] r_lo;
   logic [W-1:0] r_hi;
   logic [W-1:0] r_dwell;
   logic [W-1:0] r_sweeps;
   logic [W-1:0] r_dwell_tmr;
   logic [W-1:0] r_sweep_cnt;
   logic         r_done;
   logic         r_err;

   logic         w_take;        // start seen in IDLE without stop
   logic         w_accept;      // start accepted, counter loads lo
   logic         w_reject;      // start rejected, bounds out of order
   logic         w_load_dwell;  // entering a dwell state
   logic         w_lo_hit;      // DOWN step lands on lo: one sweep finished
   logic [W-1:0] w_sweep_inc;
   logic         w_step;
   logic [W-1:0] w_count;

   assign w_take      = (r_state == ST_IDLE) && start && !stop;
   assign w_sweep_inc = r_sweep_cnt + ONE;
   assign w_lo_hit    = (r_state == ST_DOWN) && ((w_count - ONE) == r_lo);

   // NOTE: every signal written here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_reject     = 1'b0;
      w_load_dwell = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_take) begin
               if (lo >= hi) begin
                  w_reject = 1'b1;
               end else begin
                  w_accept     = 1'b1;
                  w_next_state = ST_UP;
               end
            end
         end
         ST_UP: begin
            if ((w_count + ONE) == r_hi) begin
               if (r_dwell != '0) begin
                  w_next_state = ST_DWELL_HI;
                  w_load_dwell = 1'b1;
               end else begin
                  w_next_state = ST_DOWN;
               end
            end
         end
         ST_DWELL_HI: begin
            if (r_dwell_tmr == ONE) w_next_state = ST_DOWN;
         end
         ST_DOWN: begin
            if (w_lo_hit) begin
               if ((r_sweeps != '0) && (w_sweep_inc == r_sweeps)) begin
                  w_next_state = ST_DONE;
               end else if (r_dwell != '0) begin
                  w_next_state = ST_DWELL_LO;
                  w_load_dwell = 1'b1;
               end else begin
                  w_next_state = ST_UP;
               end
            end
         end
         ST_DWELL_LO: begin
            if (r_dwell_tmr == ONE) w_next_state = ST_UP;
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase

      // Abort overrides every other transition out of a running state.
      if (stop && (r_state != ST_IDLE)) begin
         w_next_state = ST_IDLE;
         w_load_dwell = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Shadow copies of the programming inputs, captured on any start taken
   // in IDLE so that input changes during a run have no effect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lo     <= '0;
         r_hi     <= '0;
         r_dwell  <= '0;
         r_sweeps <= '0;
      end else if (w_take) begin
         r_lo     <= lo;
         r_hi     <= hi;
         r_dwell  <= dwell;
         r_sweeps <= sweeps;
      end
   end

   // Dwell timer counts down from dwell; the state exits when it reads 1,
   // giving exactly dwell cycles in the dwell state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dwell_tmr <= '0;
      end else if (w_load_dwell) begin
         r_dwell_tmr <= r_dwell;
      end else if (((r_state == ST_DWELL_HI) || (r_state == ST_DWELL_LO)) &&
                   (r_dwell_tmr != '0)) begin
         r_dwell_tmr <= r_dwell_tmr - ONE;
      end
   end

   // Sweep counter wraps freely when sweeps is 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sweep_cnt <= '0;
      end else if (w_accept) begin
         r_sweep_cnt <= '0;
      end else if (w_lo_hit && !stop) begin
         r_sweep_cnt <= w_sweep_inc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_done <= (w_next_state == ST_DONE);
         r_err  <= w_reject;
      end
   end

   assign busy   = (r_state != ST_IDLE);
   assign mode   = ((r_state == ST_DOWN) || (r_state == ST_DWELL_HI)) ? MODE_DOWN : MODE_UP;
   assign cnt_en = (r_state == ST_UP) || (r_state == ST_DOWN);
   assign done   = r_done;
   assign err    = r_err;

   // The counter must not take the step on the edge where stop aborts.
   assign w_step = cnt_en && !stop;

   up_down_counter_ld #(
      .W (W)
   ) u_counter (
      .clk   (clk),
      .rst   (rst),
      .load  (w_accept),
      .din   (lo),
      .en    (w_step),
      .mode  (mode),
      .count (w_count)
   );

   assign count = w_count;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_updown_sweep_ctrl
// Self-checking bench for updown_sweep_ctrl. For every accepted start the
// bench builds the full expected per-cycle trace (count, mode, cnt_en, busy,
// done) from the sweep rules, then compares the DUT cycle by cycle while
// scrambling the programming inputs and pulsing start to show they are
// ignored mid-run. Stops, resets and rejected starts are layered on top.
// -----------------------------------------------------------------------------
module tb_updown_sweep_ctrl;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         stop;
   logic [W-1:0] lo;
   logic [W-1:0] hi;
   logic [W-1:0] dwell;
   logic [W-1:0] sweeps;
   logic [W-1:0] count;
   logic         mode;
   logic         cnt_en;
   logic         busy;
   logic         done;
   logic         err;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [W-1:0] count;
      logic         mode;
      logic         en;
      logic         busy;
      logic         done;
   } expd_t;

   expd_t        q[$];
   logic [W-1:0] idle_count;

   always #5 clk = ~clk;

   updown_sweep_ctrl #(
      .W (W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .stop   (stop),
      .lo     (lo),
      .hi     (hi),
      .dwell  (dwell),
      .sweeps (sweeps),
      .count  (count),
      .mode   (mode),
      .cnt_en (cnt_en),
      .busy   (busy),
      .done   (done),
      .err    (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
      n_tests++;
      if (obs !== expd) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, expd, $time);
      end
   endtask

   function automatic void push(input int c, input logic m, input logic en, input logic d);
      expd_t e;
      e.count = W'(c);
      e.mode  = m;
      e.en    = en;
      e.busy  = 1'b1;
      e.done  = d;
      q.push_back(e);
   endfunction

   // Expected trace starting with the cycle right after the accepting edge.
   // With sweeps=0 three sweeps are generated and a stop must end the run.
   function automatic void build(input int t_lo, input int t_hi, input int t_dw, input int t_sw);
      int n;
      q.delete();
      n = (t_sw == 0) ? 3 : t_sw;
      push(t_lo, 1'b0, 1'b1, 1'b0);                         // first lo, one cycle
      for (int s = 0; s < n; s++) begin
         for (int v = t_lo + 1; v < t_hi; v++) push(v, 1'b0, 1'b1, 1'b0);
         for (int k = 0; k < t_dw; k++) push(t_hi, 1'b1, 1'b0, 1'b0);
         push(t_hi, 1'b1, 1'b1, 1'b0);                      // hi, first DOWN cycle
         for (int v = t_hi - 1; v > t_lo; v--) push(v, 1'b1, 1'b1, 1'b0);
         if ((t_sw != 0) && (s == n - 1)) begin
            push(t_lo, 1'b0, 1'b0, 1'b1);                   // DONE
         end else begin
            for (int k = 0; k < t_dw; k++) push(t_lo, 1'b0, 1'b0, 1'b0);
            push(t_lo, 1'b0, 1'b1, 1'b0);
         end
      end
   endfunction

   task automatic scramble();
      lo     = W'($urandom);
      hi     = W'($urandom);
      dwell  = W'($urandom);
      sweeps = W'($urandom);
   endtask

   task automatic check_idle(input string tag, input logic e_err);
      check({tag, "_count"}, 32'(count), 32'(idle_count));
      check({tag, "_flags"}, 32'({mode, cnt_en, busy, done, err}), {27'd0, 4'b0000, e_err});
   endtask

   // stop_at / rst_at: trace index of the abort, -1 none, -2 pick at random.
   task automatic run_txn(input logic [W-1:0] t_lo, input logic [W-1:0] t_hi,
                          input logic [W-1:0] t_dw, input logic [W-1:0] t_sw,
                          input int stop_at_in, input int rst_at_in);
      int stop_at;
      int rst_at;
      build(int'(t_lo), int'(t_hi), int'(t_dw), int'(t_sw));
      stop_at = (stop_at_in == -2) ? $urandom_range(0, q.size() - 1) : stop_at_in;
      rst_at  = (rst_at_in  == -2) ? $urandom_range(0, q.size() - 1) : rst_at_in;
      if ((t_sw == '0) && (stop_at < 0) && (rst_at < 0)) stop_at = $urandom_range(0, q.size() - 1);
      lo = t_lo; hi = t_hi; dwell = t_dw; sweeps = t_sw;
      start = 1'b1;
      stop  = 1'b0;
      @(posedge clk); #1;
      for (int j = 0; j < q.size(); j++) begin
         stop  = (j == stop_at);
         start = ($urandom_range(0, 3) == 0);
         scramble();
         @(negedge clk);
         check("trace_count", 32'(count), 32'(q[j].count));
         check("trace_flags", 32'({mode, cnt_en, busy, done, err}),
               32'({q[j].mode, q[j].en, q[j].busy, q[j].done, 1'b0}));
         if (j == rst_at) begin
            #1 rst = 1'b1;
            #1;
            check("rst_count", 32'(count), 32'd0);
            check("rst_flags", 32'({mode, cnt_en, busy, done, err}), 32'd0);
            start = 1'b0;
            stop  = 1'b0;
            idle_count = '0;
            @(negedge clk) rst = 1'b0;
            @(posedge clk); #1;
            @(negedge clk) check_idle("after_rst", 1'b0);
            @(posedge clk); #1;
            return;
         end
         @(posedge clk); #1;
         if (j == stop_at) begin
            stop  = 1'b0;
            start = 1'b0;
            idle_count = q[j].count;
            @(negedge clk) check_idle("stopped", 1'b0);
            @(posedge clk); #1;
            @(negedge clk) check_idle("stopped_hold", 1'b0);
            @(posedge clk); #1;
            return;
         end
      end
      start = 1'b0;
      idle_count = t_lo;
      @(negedge clk) check_idle("end_idle", 1'b0);
      @(posedge clk); #1;
   endtask

   task automatic reject(input logic [W-1:0] t_lo, input logic [W-1:0] t_hi);
      lo = t_lo; hi = t_hi; dwell = W'($urandom); sweeps = W'($urandom);
      start = 1'b1;
      stop  = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      scramble();
      @(negedge clk) check_idle("reject", 1'b1);
      @(posedge clk); #1;
      @(negedge clk) check_idle("reject_clr", 1'b0);
      @(posedge clk); #1;
   endtask

   task automatic start_with_stop();
      lo = 4'd1; hi = 4'd5; dwell = 4'd0; sweeps = 4'd1;
      start = 1'b1;
      stop  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      stop  = 1'b0;
      @(negedge clk) check_idle("start_stop", 1'b0);
      @(posedge clk); #1;
      @(negedge clk) check_idle("start_stop_hold", 1'b0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [W-1:0] r_lo;
      logic [W-1:0] r_hi;
      int           stop_sel;
      int           rst_sel;

      rst = 1'b1; start = 1'b0; stop = 1'b0;
      lo = '0; hi = '0; dwell = '0; sweeps = '0;
      idle_count = '0;
      #12;
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk) check_idle("reset_idle", 1'b0);
      end
      @(posedge clk); #1;

      run_txn(4'd2, 4'd5,  4'd0, 4'd1, -1, -1);
      run_txn(4'd1, 4'd3,  4'd2, 4'd2, -1, -1);
      reject(4'd7, 4'd7);
      reject(4'd9, 4'd4);
      run_txn(4'd0, 4'd15, 4'd0, 4'd0,  9, -1);   // stop at count 9 going up
      start_with_stop();
      run_txn(4'd2, 4'd10, 4'd0, 4'd1, -1, 12);   // reset at count 6 going down
      run_txn(4'd0, 4'd15, 4'd1, 4'd1, -1, -1);   // full range

      for (int it = 0; it < 40; it++) begin
         r_lo = W'($urandom);
         r_hi = W'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            start_with_stop();
         end else if (r_lo >= r_hi) begin
            reject(r_lo, r_hi);
         end else begin
            stop_sel = ($urandom_range(0, 4) == 0) ? -2 : -1;
            rst_sel  = ($urandom_range(0, 9) == 0) ? -2 : -1;
            run_txn(r_lo, r_hi, W'($urandom_range(0, 3)), W'($urandom_range(0, 3)),
                    stop_sel, rst_sel);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/updown_sweep_ctrl.md
# updown_sweep_ctrl

Sequencing controller for the team's 4-bit up/down counter datapath. It drives the counter in a bounded ping-pong sweep between programmable low and high limits, with an optional dwell at each limit and a programmable number of sweeps. A start/stop control interface is provided, with busy, done and err status. It sits between the control logic and the counter, owning the counter's `mode`, `en` and `load` inputs.

## Interface
- `W`, default 4: count, bound and dwell width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `stop`  in  1  abort; sampled in every state.
- `lo`  in  W  lower bound.
- `hi`  in  W  upper bound.
- `dwell`  in  W  extra hold cycles at each bound; 0 means no hold.
- `sweeps`  in  W  number of full up-then-down sweeps; 0 means run until `stop`.
- `count`  out  W  current counter value.
- `mode`  out  1  direction: 0 is up, 1 is down.
- `cnt_en`  out  1  counter steps on this edge.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on completion.
- `err`  out  1  one-cycle pulse on a rejected start.

## Operation
- States:
  - IDLE
  - UP
  - DWELL_HI
  - DOWN
  - DWELL_LO
  - DONE
- Reset values:
  - state = IDLE
  - count = 0, mode = 0, cnt_en = 0
  - busy = 0, done = 0, err = 0
  - sweep counter = 0, dwell timer = 0
- IDLE with `start`=1 and `stop`=0:
  - `lo`, `hi`, `dwell` and `sweeps` are latched into shadow registers; later input changes are ignored until IDLE.
  - If lo ≥ hi: `err`=1 for the next cycle, state stays IDLE, count is unchanged.
  - Otherwise: count <= lo, sweep counter <= 0, state <= UP.
- UP: count <= count+1 on each edge.
  - On the edge where count+1 == hi, next state is DWELL_HI if dwell ≠ 0, else DOWN.
- DWELL_HI / DWELL_LO:
  - Dwell timer is loaded with `dwell` on entry; count holds.
  - Exit after exactly `dwell` cycles: DWELL_HI goes to DOWN, DWELL_LO goes to UP.
- DOWN: count <= count−1 on each edge.
  - On the edge where count−1 == lo, the sweep counter increments.
  - If sweeps ≠ 0 and the incremented value == sweeps, next state is DONE.
  - Otherwise next state is DWELL_LO if dwell ≠ 0, else UP.
- DONE:
  - `done`=1, count holds lo.
  - Returns to IDLE on the next edge.
- `stop`=1 in any non-IDLE state: next state IDLE, count holds its current value, no `done` pulse.
- `stop` and `start` asserted together in IDLE: stop wins, start is ignored, no `err`.
- `start` in any non-IDLE state is ignored.
- Outputs:
  - `mode`=1 in DOWN and DWELL_HI; 0 otherwise.
  - `cnt_en`=1 only in UP and DOWN.
- Sweep counter: W bits. With sweeps=0 it wraps freely and never terminates.
- Full range lo=0, hi=2^W−1 is legal; count never wraps past a bound.

## Timing
- All outputs are registered except `busy`, `mode` and `cnt_en`, which decode the state register.
- Start accepted at edge k: count=lo and state=UP are visible after edge k.
- With dwell=0 the count period is 2·(hi−lo) cycles; each bound value appears for one cycle.
- With dwell=d, hi and lo each appear for d+1 cycles. Exception: the first lo after start appears for 1 cycle.
- The final sweep ends with count=lo and state DONE in the same cycle. `done` is high for that cycle; busy=0 and IDLE follow one cycle later.
- `err` is asserted one cycle after the rejected start.
- Asynchronous reset mid-operation forces all reset values immediately. Operation resumes only on a new `start`.

## Structure
- Package `updown_sweep_pkg` holds:
  - state enumeration (3-bit encoding, IDLE = 0)
  - default W
  - direction constants MODE_UP = 0, MODE_DOWN = 1
- Sub-module `up_down_counter_ld`: W-bit counter with `load`, `din`, `en` and `mode` inputs, same async active-high `rst`.
- The FSM, shadow registers, dwell timer and sweep counter live in the top level.

## Test plan
- Reset released, no start → count=0, busy=0, done=0 and err=0 held for 20 cycles.
- lo=2, hi=5, dwell=0, sweeps=1, start → count 2,3,4,5,4,3,2 on consecutive cycles; done pulses with count=2; busy drops the next cycle.
- lo=1, hi=3, dwell=2, sweeps=2 → count 1,2,3,3,3,2,1,1,1,2,3,3,3,2,1 then done; mode=1 exactly during the 3-holds and the down steps.
- lo=7, hi=7, start → err pulse one cycle later, state IDLE, count unchanged; lo=9, hi=4 gives the same result.
- lo=0, hi=15, sweeps=0, stop asserted at count=9 while going up → IDLE next cycle, count=9 held, no done; start together with stop in IDLE → ignored.
- Assert rst mid-DOWN at count=6 → count=0 and busy=0 immediately; start with changed inputs mid-run has no effect on the latched bounds.
